axi4_lite_slave_responder: RTL
==============================

Name: axi4_lite_slave_responder

Overview:
AXI4-Lite subordinate endpoint that terminates the channels driven by the master-side BFM: AW/W/B for writes and AR/R for reads.
- Backs the bus with a small word-addressed register bank.
- Handshake timing is programmable so the verification environment can stress master-side valid/ready handling.
- Sits on the slave side of the AXI4-Lite interconnect, inside the slave agent's BFM, and talks to the master BFM over the shared handshake signals.

Parameters:
ADDR_WIDTH, 32, width of awaddr/araddr
DATA_WIDTH, 32, width of wdata/rdata; must be 32 or 64
NUM_REGS, 16, number of DATA_WIDTH registers; power of two, at least 2
READY_DELAY, 0, cycles from valid first seen to ready pulse on AW, W and AR; range 0..15

Ports:
aclk  input  1  bus clock
aresetn  input  1  asynchronous active-low reset
awvalid  input  1  write address valid
awready  output  1  write address ready
awaddr  input  ADDR_WIDTH  write byte address
wvalid  input  1  write data valid
wready  output  1  write data ready
wdata  input  DATA_WIDTH  write data
wstrb  input  DATA_WIDTH/8  byte enables
bvalid  output  1  write response valid
bready  input  1  write response ready
bresp  output  2  write response
arvalid  input  1  read address valid
arready  output  1  read address ready
araddr  input  ADDR_WIDTH  read byte address
rvalid  output  1  read data valid
rready  input  1  read data ready
rdata  output  DATA_WIDTH  read data
rresp  output  2  read response

Behaviour:
- Reset (aresetn low, asynchronous): all readies, bvalid, rvalid = 0; bresp, rresp, rdata = 0; all registers = 0; both FSMs idle; delay counters = 0. Reset mid-transaction drops the transaction with no response.
- Address decode: LSB = log2(DATA_WIDTH/8).
  - Index = addr[LSB +: log2(NUM_REGS)]; low LSB bits are ignored (unaligned accesses are treated as aligned).
  - Address >= NUM_REGS*DATA_WIDTH/8 is out of range: response SLVERR (2'b10), no register write, rdata = 0.
  - In-range response: OKAY (2'b00).
- Ready generation (per AW/W/AR channel, registered):
  - READY_DELAY = 0: ready is high whenever that channel's slot is free (ready-before-valid). It rises on the first edge after reset release.
  - READY_DELAY = N > 0: counter starts on the first cycle valid is high with the slot free. Ready is a single-cycle pulse asserted N cycles later, and the handshake occurs in that cycle. If valid drops early (protocol violation), the counter clears.
  - Ready is never high while the slot is occupied.
- Write FSM, states W_IDLE, W_COLLECT, W_RESP:
  - AW and W are captured independently, in either order or in the same cycle.
  - W_IDLE to W_COLLECT when exactly one of AW/W is captured.
  - W_IDLE or W_COLLECT to W_RESP on the edge where both are held. On that same edge, the register update (per-byte via wstrb) commits and bresp is set.
  - bvalid is asserted the cycle after the last capture and holds, with bresp stable, until bready. Then go to W_IDLE with both slots freed.
  - awready and wready are 0 throughout W_RESP.
- Read FSM, states R_IDLE, R_DATA:
  - On the AR handshake edge, rdata/rresp are loaded from the current register contents and the FSM goes to R_DATA with rvalid = 1.
  - rvalid, rdata and rresp are held stable until rready, then return to R_IDLE.
  - arready is 0 in R_DATA.
  - Minimum read latency: 1 cycle from handshake to rvalid.
- Read and write to the same register on the same edge (AR handshake and write commit): read returns the pre-write value.
- Read and write channels are fully independent; there is at most one outstanding transaction per direction.

Decomposition:
- Extend Axi4LiteGlobalsPkg with:
  - response constants OKAY = 2'b00 and SLVERR = 2'b10;
  - enum typedefs for the write FSM (W_IDLE, W_COLLECT, W_RESP) and the read FSM (R_IDLE, R_DATA).
- One sub-module, axi4_lite_ready_gen: per-channel slot-free, valid, delay counter and registered ready pulse. Instantiated three times, for AW, W and AR.

Test Plan:
- READY_DELAY = 0: write awaddr 0x08, wdata 0xDEADBEEF, wstrb 0xF with AW and W in the same cycle -> bvalid 1 cycle later, bresp 0x0. Read 0x08 -> rdata 0xDEADBEEF, rresp 0x0, rvalid 1 cycle after the AR handshake.
- W precedes AW by 3 cycles, wstrb 0x3, wdata 0x12345678 to 0x04 that was preloaded with 0xFFFFFFFF -> single bresp OKAY; read 0x04 gives 0xFFFF5678.
- READY_DELAY = 4: awvalid asserted at cycle 0 -> awready is a one-cycle pulse at cycle 4. Same check applies to W and AR.
- Out-of-range write to 0x40 (NUM_REGS = 16) -> bresp SLVERR, all registers unchanged. Read 0x40 -> rdata 0, rresp SLVERR.
- bready held low for 5 cycles -> bvalid and bresp stay stable and awready stays 0. A concurrent read to a different register completes normally.
- aresetn pulsed low while bvalid = 1 -> bvalid drops immediately, registers read back 0, and the next write completes with OKAY.

Source files
------------

// File: rtl/axi4_lite_slave_responder_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite slave responder.
package axi4_lite_slave_responder_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COLLECT,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi4_lite_ready_gen.sv
// Per-channel slot tracking and registered ready generation for one AXI4-Lite
// request channel (AW, W or AR).
module axi4_lite_ready_gen #(
  parameter int READY_DELAY = 0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic valid_i,
  input  logic release_i,
  output logic ready_o,
  output logic held_o
);

  logic full_q, full_d;
  logic ready_q, ready_d;
  logic fire;

  assign fire    = valid_i & ready_q;
  assign ready_o = ready_q;
  // Slot counts as occupied on the handshake edge itself so the FSM can act on it.
  assign held_o  = full_q | fire;

  always_comb begin
    full_d = full_q;
    if (fire) begin
      full_d = 1'b1;
    end else if (release_i) begin
      full_d = 1'b0;
    end
  end

  generate
    if (READY_DELAY == 0) begin : g_nodelay
      assign ready_d = ~full_d;
    end else begin : g_delay
      localparam logic [3:0] LAST = 4'(READY_DELAY - 1);
      logic [3:0] cnt_q, cnt_d;
      logic       counting;

      // Counting stops while the pulse is out; a dropped valid restarts from zero.
      assign counting = valid_i & ~full_q & ~ready_q;
      assign ready_d  = counting && (cnt_q == LAST);

      always_comb begin
        cnt_d = 4'd0;
        if (counting && (cnt_q != LAST)) begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          cnt_q <= 4'd0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/axi4_lite_slave_responder.sv
// AXI4-Lite subordinate backed by a small word-addressed register bank, with
// programmable ready latency on the AW, W and AR channels.
module axi4_lite_slave_responder
  import axi4_lite_slave_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int READY_DELAY = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_W);

  w_state_e w_state_q;
  r_state_e r_state_q;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_held, w_held, ar_held;
  logic aw_fire, w_fire;
  logic b_done, r_done;

  assign b_done  = bvalid_q & bready;
  assign r_done  = rvalid_q & rready;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  axi4_lite_ready_gen #(.READY_DELAY(READY_DELAY)) u_aw_rdy (
    .aclk(aclk), .aresetn(aresetn), .valid_i(awvalid), .release_i(b_done),
    .ready_o(awready), .held_o(aw_held)
  );

  axi4_lite_ready_gen #(.READY_DELAY(READY_DELAY)) u_w_rdy (
    .aclk(aclk), .aresetn(aresetn), .valid_i(wvalid), .release_i(b_done),
    .ready_o(wready), .held_o(w_held)
  );

  axi4_lite_ready_gen #(.READY_DELAY(READY_DELAY)) u_ar_rdy (
    .aclk(aclk), .aresetn(aresetn), .valid_i(arvalid), .release_i(r_done),
    .ready_o(arready), .held_o(ar_held)
  );

  // A beat arriving on the commit edge has not been latched yet, so use the bus value.
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] eff_data;
  logic [STRB_W-1:0]     eff_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  wr_ok, rd_ok;

  assign eff_addr = aw_fire ? awaddr : awaddr_q;
  assign eff_data = w_fire ? wdata : wdata_q;
  assign eff_strb = w_fire ? wstrb : wstrb_q;
  assign wr_idx   = eff_addr[LSB +: IDX_W];
  assign wr_ok    = eff_addr < ADDR_LIMIT;
  assign rd_idx   = araddr[LSB +: IDX_W];
  assign rd_ok    = araddr < ADDR_LIMIT;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (aw_fire) awaddr_q <= awaddr;
      if (w_fire) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      case (w_state_q)
        W_IDLE, W_COLLECT: begin
          if (aw_held && w_held) begin
            if (wr_ok) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (eff_strb[b]) regs_q[wr_idx][8*b +: 8] <= eff_data[8*b +: 8];
              end
            end
            bresp_q   <= wr_ok ? OKAY : SLVERR;
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end else if (aw_fire || w_fire) begin
            w_state_q <= W_COLLECT;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Reads sample regs_q before any same-edge write commit lands.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_held) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_ok ? regs_q[rd_idx] : '0;
            rresp_q   <= rd_ok ? OKAY : SLVERR;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

endmodule
